rename_ckpt: RTL and testbench
==============================

// Module: rename_ckpt
// PURPOSE
// Single-wide register-rename stage with an integrated circular free list and up to CHECKPOINTS branch snapshots.
// - Sits between the decode skid buffer and dispatch.
// - Maps rs1/rs2/rd to physical registers, allocates pd_new, reports pd_old, assigns a ROB tag.
// - Each branch gets a checkpoint tag. A mispredict on any in-flight tag restores map, free list and ROB tag in one cycle.
// - Out-of-order correct resolutions retire their checkpoints.
// PARAMETERS
// ARCH_REGS    32   architectural registers; x0 maps to p0 permanently
// PREGS        128  physical registers; FL_DEPTH = PREGS-ARCH_REGS
// ROB_DEPTH    16   ROB tag modulus; ROB_TAG_W = $clog2(ROB_DEPTH)
// CHECKPOINTS  4    max unresolved branches; CK_W = $clog2(CHECKPOINTS)
// PAYLOAD_W    64   opaque decode fields (pc, imm, opcode, fu bits), passed through unchanged
// PORTS
// clk               in   1          clock, all state on rising edge
// reset_n           in   1          asynchronous, active-low reset
// in_valid          in   1          decode entry valid
// in_ready          out  1          stage accepts this cycle
// in_rs1/in_rs2/in_rd in 5 each     architectural register indices
// in_wr_rd          in   1          instruction writes rd (ignored when in_rd==0)
// in_is_br          in   1          instruction is a conditional branch and needs a checkpoint
// in_payload        in   PAYLOAD_W  passthrough
// free_valid        in   1          ROB commit frees a physical register
// free_preg         in   7          preg to free; p0 is ignored
// br_valid          in   1          branch resolution strobe
// br_mispredict     in   1          1 = mispredict, 0 = correct
// br_tag            in   CK_W       checkpoint being resolved
// out_valid         out  1          renamed entry valid
// out_ready         in   1          dispatch accepts
// out_ps1/out_ps2   out  7 each     physical sources
// out_pd_new        out  7          allocated dest; 0 when no allocation
// out_pd_old        out  7          prior mapping of rd; freed by the ROB at commit
// out_rob_tag       out  ROB_TAG_W  program-order tag
// out_br_tag        out  CK_W       checkpoint tag; valid when out_is_br
// out_is_br         out  1          passthrough of in_is_br
// out_payload       out  PAYLOAD_W  passthrough
// BEHAVIOUR
// - Reset (async):
//   - map[i]=i; free list holds p32..p127 in order; fl_head=fl_tail=0, fl_count=FL_DEPTH.
//   - rob_ctr=0; checkpoint head/tail/count=0, all checkpoint slots invalid.
//   - out_valid=0 and all out_* = 0.
// - alloc = in_wr_rd && in_rd!=0.
// - in_ready = (out_ready||!out_valid) && !(alloc && fl_count==0) && !(in_is_br && ck_count==CHECKPOINTS) && !(br_valid&&br_mispredict).
// - Accept = in_valid && in_ready. Latency is 1 cycle: outputs are registered on accept, and out_valid is held until out_ready.
// - Sources and pd_old read the map before this instruction's own update. rs==rd reads the old mapping.
// - On accept with alloc: pd_new = list[fl_head], fl_head++ mod FL_DEPTH, map[rd] = pd_new.
// - rob_ctr increments mod ROB_DEPTH on every accept.
// - Free: when free_valid && free_preg!=0, list[fl_tail]=free_preg, fl_tail++ mod FL_DEPTH, fl_count++.
//   - Alloc and free in the same cycle leave fl_count unchanged.
//   - Frees are never rolled back.
// - Checkpoint (accepted branch) is written at slot ck_tail; out_br_tag = ck_tail. It stores:
//   - map as it stands after this instruction;
//   - fl_head after this instruction;
//   - rob_ctr+1;
//   - fl_count after this cycle's update, with a per-slot frees_since counter cleared to 0.
//   - ck_tail++ and ck_count++.
// - Every valid slot's frees_since increments on each accepted free.
// - Correct resolve of tag t marks slot t done. The head advances over contiguous done slots, one slot per cycle, and ck_count decrements per slot retired.
// - Mispredict on tag t (takes effect next edge):
//   - map, fl_head and rob_ctr are restored from slot t.
//   - fl_count = slot.fl_count + slot.frees_since + (this cycle's free).
//   - Slot t and all younger slots (t..ck_tail-1) are invalidated; ck_tail = t.
//   - out_valid is cleared, since everything held in the output register is younger.
//   - No accept happens that cycle.
// - Simultaneous correct resolve and checkpoint allocation are both applied.
// - br_valid on an invalid slot has no effect.
// - Pointer wrap: fl_head, fl_tail and ck pointers wrap modulo depth. FL_DEPTH need not be a power of 2.
// - Reset asserted mid-operation: everything returns to reset state immediately. In-flight outputs are lost.
// TESTING
// - Reset, then rename add x5,x1,x2 -> ps1=1, ps2=2, pd_new=32, pd_old=5, rob_tag=0. The next write to x5 reads ps=32, pd_new=33.
// - Writes to x0, stores and branches -> pd_new=0, free list untouched. After 96 allocations with no frees, in_ready=0. One free of p40 -> the next pd_new is 40.
// - Branch (tag0), then 3 allocs, 1 free, then mispredict tag0:
//   - next pd_new equals the preg after the branch;
//   - fl_count = snapshot+1;
//   - rob_tag = branch tag+1;
//   - map restored.
// - 4 branches outstanding -> 5th branch stalls. Correct resolves in order 2,0,1 -> ck_count 4,3,1 after head walk; branch accepted.
// - Mispredict in the same cycle as in_valid with out_valid=1 and out_ready=0 -> out_valid=0, no accept. Accept resumes the following cycle.
// - Assert reset_n=0 asynchronously between edges -> out_valid=0 immediately. After release, the first pd_new is 32.

Source files
------------

// File: rtl/rename_ckpt.sv
// rename_ckpt: single-wide rename stage with circular free list and
// branch checkpoints restored in one cycle on mispredict.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   in_valid/in_ready             decode side handshake
//   in_rs1/in_rs2/in_rd/in_wr_rd  architectural operands
//   in_is_br, in_payload          branch flag, opaque passthrough
//   free_valid/free_preg          ROB commit frees a physical reg
//   br_valid/br_mispredict/br_tag branch resolution
//   out_valid/out_ready           dispatch side handshake
//   out_ps1/out_ps2/out_pd_new/out_pd_old/out_rob_tag/out_br_tag/
//   out_is_br/out_payload         renamed entry (registered)
module rename_ckpt #(
  parameter int ARCH_REGS   = 32,
  parameter int PREGS       = 128,
  parameter int ROB_DEPTH   = 16,
  parameter int CHECKPOINTS = 4,
  parameter int PAYLOAD_W   = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [$clog2(ARCH_REGS)-1:0]   in_rs1,
  input  logic [$clog2(ARCH_REGS)-1:0]   in_rs2,
  input  logic [$clog2(ARCH_REGS)-1:0]   in_rd,
  input  logic                           in_wr_rd,
  input  logic                           in_is_br,
  input  logic [PAYLOAD_W-1:0]           in_payload,
  input  logic                           free_valid,
  input  logic [$clog2(PREGS)-1:0]       free_preg,
  input  logic                           br_valid,
  input  logic                           br_mispredict,
  input  logic [$clog2(CHECKPOINTS)-1:0] br_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(PREGS)-1:0]       out_ps1,
  output logic [$clog2(PREGS)-1:0]       out_ps2,
  output logic [$clog2(PREGS)-1:0]       out_pd_new,
  output logic [$clog2(PREGS)-1:0]       out_pd_old,
  output logic [$clog2(ROB_DEPTH)-1:0]   out_rob_tag,
  output logic [$clog2(CHECKPOINTS)-1:0] out_br_tag,
  output logic                           out_is_br,
  output logic [PAYLOAD_W-1:0]           out_payload
);

  localparam int PW       = $clog2(PREGS);
  localparam int FL_DEPTH = PREGS - ARCH_REGS;
  localparam int FW       = $clog2(FL_DEPTH);
  localparam int CW       = $clog2(FL_DEPTH + 1);
  localparam int RW       = $clog2(ROB_DEPTH);
  localparam int KW       = $clog2(CHECKPOINTS);
  localparam int KCW      = $clog2(CHECKPOINTS + 1);

  typedef logic [PW-1:0] preg_t;
  typedef preg_t [ARCH_REGS-1:0] map_t;

  typedef struct packed {
    preg_t                ps1;
    preg_t                ps2;
    preg_t                pd_new;
    preg_t                pd_old;
    logic [RW-1:0]        rob;
    logic [KW-1:0]        br_tag;
    logic                 is_br;
    logic [PAYLOAD_W-1:0] payload;
  } out_t;

  map_t            map_q, map_d, map_upd;
  preg_t           fl_q [FL_DEPTH];
  logic [FW-1:0]   fl_head_q, fl_head_d, fl_head_acc;
  logic [FW-1:0]   fl_tail_q, fl_tail_d;
  logic [CW-1:0]   fl_count_q, fl_count_d, fl_count_upd;
  logic [RW-1:0]   rob_q, rob_d;

  map_t            ck_map_q     [CHECKPOINTS];
  logic [FW-1:0]   ck_fl_head_q [CHECKPOINTS];
  logic [RW-1:0]   ck_rob_q     [CHECKPOINTS];
  logic [CW-1:0]   ck_cnt_q     [CHECKPOINTS];
  logic [CW-1:0]   ck_frees_q   [CHECKPOINTS];
  logic [CHECKPOINTS-1:0] ck_valid_q, ck_done_q, ck_kill;
  logic [KW-1:0]   ck_head_q, ck_head_d;
  logic [KW-1:0]   ck_tail_q, ck_tail_d;
  logic [KCW-1:0]  ck_count_q, ck_count_d, ck_live;

  out_t            out_q, out_d;
  logic            out_valid_q, out_valid_d;

  logic            alloc, misp_req, misp, corr;
  logic            acc, do_alloc, do_ck, free_acc;
  logic            retire, retire_eff;
  preg_t           pd_new;

  function automatic logic [FW-1:0] fl_inc(input logic [FW-1:0] p);
    return (p == FW'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [KW-1:0] ck_inc(input logic [KW-1:0] p);
    return (p == KW'(CHECKPOINTS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ring distance from slot a forward to slot b.
  function automatic logic [KW-1:0] ck_dist(input logic [KW-1:0] a,
                                            input logic [KW-1:0] b);
    return KW'((int'(b) + CHECKPOINTS - int'(a)) % CHECKPOINTS);
  endfunction

  always_comb begin
    alloc    = in_wr_rd && (in_rd != '0);
    misp_req = br_valid && br_mispredict;
    misp     = misp_req && ck_valid_q[br_tag];
    corr     = br_valid && !br_mispredict && ck_valid_q[br_tag];
    free_acc = free_valid && (free_preg != '0);

    in_ready = (out_ready || !out_valid_q)
            && !(alloc && (fl_count_q == '0))
            && !(in_is_br && (ck_count_q == KCW'(CHECKPOINTS)))
            && !misp_req;

    acc      = in_valid && in_ready;
    do_alloc = acc && alloc;
    do_ck    = acc && in_is_br;
    pd_new   = fl_q[fl_head_q];

    map_upd = map_q;
    if (do_alloc) map_upd[in_rd] = pd_new;

    fl_head_acc  = do_alloc ? fl_inc(fl_head_q) : fl_head_q;
    fl_count_upd = fl_count_q + CW'(free_acc) - CW'(do_alloc);

    // Slots from br_tag up to the tail are younger than the mispredict.
    ck_live = ck_count_q - KCW'(ck_dist(ck_head_q, br_tag));
    for (int i = 0; i < CHECKPOINTS; i++) begin
      ck_kill[i] = KCW'(ck_dist(br_tag, KW'(i))) < ck_live;
    end

    retire     = ck_valid_q[ck_head_q] && ck_done_q[ck_head_q];
    retire_eff = retire && !(misp && ck_kill[ck_head_q]);

    ck_head_d = retire_eff ? ck_inc(ck_head_q) : ck_head_q;
    if (misp) begin
      ck_tail_d  = br_tag;
      ck_count_d = KCW'(ck_dist(ck_head_q, br_tag)) - KCW'(retire_eff);
    end else begin
      ck_tail_d  = do_ck ? ck_inc(ck_tail_q) : ck_tail_q;
      ck_count_d = ck_count_q + KCW'(do_ck) - KCW'(retire_eff);
    end

    fl_tail_d = free_acc ? fl_inc(fl_tail_q) : fl_tail_q;
    if (misp) begin
      map_d      = ck_map_q[br_tag];
      fl_head_d  = ck_fl_head_q[br_tag];
      fl_count_d = ck_cnt_q[br_tag] + ck_frees_q[br_tag]
                 + CW'(free_acc);
      rob_d      = ck_rob_q[br_tag];
    end else begin
      map_d      = map_upd;
      fl_head_d  = fl_head_acc;
      fl_count_d = fl_count_upd;
      rob_d      = acc ? rob_q + 1'b1 : rob_q;
    end

    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (misp) begin
      out_valid_d = 1'b0;
    end else if (acc) begin
      out_valid_d    = 1'b1;
      out_d.ps1      = map_q[in_rs1];
      out_d.ps2      = map_q[in_rs2];
      out_d.pd_new   = do_alloc ? pd_new : '0;
      out_d.pd_old   = alloc ? map_q[in_rd] : '0;
      out_d.rob      = rob_q;
      out_d.br_tag   = in_is_br ? ck_tail_q : '0;
      out_d.is_br    = in_is_br;
      out_d.payload  = in_payload;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
      for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= PW'(ARCH_REGS + i);
      fl_head_q   <= '0;
      fl_tail_q   <= '0;
      fl_count_q  <= CW'(FL_DEPTH);
      rob_q       <= '0;
      for (int i = 0; i < CHECKPOINTS; i++) begin
        ck_map_q[i]     <= '0;
        ck_fl_head_q[i] <= '0;
        ck_rob_q[i]     <= '0;
        ck_cnt_q[i]     <= '0;
        ck_frees_q[i]   <= '0;
      end
      ck_valid_q  <= '0;
      ck_done_q   <= '0;
      ck_head_q   <= '0;
      ck_tail_q   <= '0;
      ck_count_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      map_q       <= map_d;
      fl_head_q   <= fl_head_d;
      fl_tail_q   <= fl_tail_d;
      fl_count_q  <= fl_count_d;
      rob_q       <= rob_d;
      ck_head_q   <= ck_head_d;
      ck_tail_q   <= ck_tail_d;
      ck_count_q  <= ck_count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      if (free_acc) fl_q[fl_tail_q] <= free_preg;
      for (int i = 0; i < CHECKPOINTS; i++) begin
        if (free_acc && ck_valid_q[i]) begin
          ck_frees_q[i] <= ck_frees_q[i] + 1'b1;
        end
        if (corr && (br_tag == KW'(i))) ck_done_q[i] <= 1'b1;
        if (retire_eff && (ck_head_q == KW'(i))) begin
          ck_valid_q[i] <= 1'b0;
          ck_done_q[i]  <= 1'b0;
        end
        if (misp && ck_kill[i]) begin
          ck_valid_q[i] <= 1'b0;
          ck_done_q[i]  <= 1'b0;
        end
        if (do_ck && (ck_tail_q == KW'(i))) begin
          ck_valid_q[i]   <= 1'b1;
          ck_done_q[i]    <= 1'b0;
          ck_map_q[i]     <= map_upd;
          ck_fl_head_q[i] <= fl_head_acc;
          ck_rob_q[i]     <= rob_q + 1'b1;
          ck_cnt_q[i]     <= fl_count_upd;
          ck_frees_q[i]   <= '0;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ps1     = out_q.ps1;
  assign out_ps2     = out_q.ps2;
  assign out_pd_new  = out_q.pd_new;
  assign out_pd_old  = out_q.pd_old;
  assign out_rob_tag = out_q.rob;
  assign out_br_tag  = out_q.br_tag;
  assign out_is_br   = out_q.is_br;
  assign out_payload = out_q.payload;

endmodule

// File: tb/tb_rename_ckpt.sv
// tb_rename_ckpt: directed checks of rename, free list, checkpoints,
// mispredict restore and async reset.
module tb_rename_ckpt;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_wr_rd, in_is_br;
  logic [63:0] in_payload;
  logic        free_valid;
  logic [6:0]  free_preg;
  logic        br_valid, br_mispredict;
  logic [1:0]  br_tag;
  logic        out_valid, out_ready;
  logic [6:0]  out_ps1, out_ps2, out_pd_new, out_pd_old;
  logic [3:0]  out_rob_tag;
  logic [1:0]  out_br_tag;
  logic        out_is_br;
  logic [63:0] out_payload;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] pl = 64'h1234_5678_9abc_0000;

  rename_ckpt dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_wr_rd(in_wr_rd), .in_is_br(in_is_br),
    .in_payload(in_payload),
    .free_valid(free_valid), .free_preg(free_preg),
    .br_valid(br_valid), .br_mispredict(br_mispredict),
    .br_tag(br_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ps1(out_ps1), .out_ps2(out_ps2),
    .out_pd_new(out_pd_new), .out_pd_old(out_pd_old),
    .out_rob_tag(out_rob_tag), .out_br_tag(out_br_tag),
    .out_is_br(out_is_br), .out_payload(out_payload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_wr_rd = 0; in_is_br = 0; in_payload = 0;
    free_valid = 0; free_preg = 0;
    br_valid = 0; br_mispredict = 0; br_tag = 0;
    out_ready = 1;
  endtask

  task automatic rn(input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [4:0] rd, input logic wr,
                    input logic br);
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_wr_rd = wr; in_is_br = br; in_payload = pl;
    pl = pl + 1;
    in_valid = 1;
    cyc(1);
    in_valid = 0; in_wr_rd = 0; in_is_br = 0;
  endtask

  task automatic free_one(input logic [6:0] p);
    free_valid = 1; free_preg = p;
    cyc(1);
    free_valid = 0; free_preg = 0;
  endtask

  task automatic resolve(input logic [1:0] t, input logic mp);
    br_valid = 1; br_mispredict = mp; br_tag = t;
    cyc(1);
    br_valid = 0; br_mispredict = 0; br_tag = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    cyc(1);
    reset_n = 1;
  endtask

  initial begin
    idle();
    reset_n = 0;
    cyc(2);
    check("rst_valid", out_valid, 0);
    check("rst_pd_new", out_pd_new, 0);
    check("rst_rob", out_rob_tag, 0);
    check("rst_ready", in_ready, 1);
    check("rst_flcnt", dut.fl_count_q, 96);
    reset_n = 1;

    // basic rename
    rn(1, 2, 5, 1, 0);
    check("add_valid", out_valid, 1);
    check("add_ps1", out_ps1, 1);
    check("add_ps2", out_ps2, 2);
    check("add_pdnew", out_pd_new, 32);
    check("add_pdold", out_pd_old, 5);
    check("add_rob", out_rob_tag, 0);
    check("add_payload", out_payload, 64'h1234_5678_9abc_0000);
    rn(5, 5, 5, 1, 0);
    check("x5_ps1", out_ps1, 32);
    check("x5_pdnew", out_pd_new, 33);
    check("x5_pdold", out_pd_old, 32);
    check("x5_rob", out_rob_tag, 1);
    rn(5, 0, 0, 1, 0);
    check("x0_pdnew", out_pd_new, 0);
    check("x0_rob", out_rob_tag, 2);
    rn(5, 6, 7, 0, 0);
    check("st_pdnew", out_pd_new, 0);
    check("st_ps2", out_ps2, 6);
    check("flcnt_94", dut.fl_count_q, 94);

    // drain the free list
    for (int i = 0; i < 94; i++) begin
      rn(0, 0, 5'(1 + i % 31), 1, 0);
    end
    check("last_pdnew", out_pd_new, 127);
    check("rob_wrap", out_rob_tag, 1);
    check("flcnt_0", dut.fl_count_q, 0);
    in_valid = 1; in_wr_rd = 1; in_rd = 3;
    #1;
    check("empty_stall", in_ready, 0);
    cyc(1);
    in_valid = 0; in_wr_rd = 0;
    check("empty_noacc", out_valid, 0);
    free_one(40);
    check("flcnt_1", dut.fl_count_q, 1);
    rn(3, 0, 3, 1, 0);
    check("reuse_40", out_pd_new, 40);

    // branch snapshot and mispredict restore
    do_reset();
    rn(0, 0, 7, 1, 0);
    check("b_pre_pd", out_pd_new, 32);
    rn(1, 2, 0, 0, 1);
    check("b_isbr", out_is_br, 1);
    check("b_tag", out_br_tag, 0);
    check("b_rob", out_rob_tag, 1);
    check("b_pdnew", out_pd_new, 0);
    rn(0, 0, 1, 1, 0);
    rn(0, 0, 2, 1, 0);
    rn(0, 0, 3, 1, 0);
    check("b_x3_pd", out_pd_new, 35);
    check("b_x3_rob", out_rob_tag, 4);
    free_one(7);
    check("b_flcnt", dut.fl_count_q, 93);
    rn(0, 0, 4, 1, 0);
    check("b_x4_pd", out_pd_new, 36);
    out_ready = 0;
    in_valid = 1; in_rs1 = 1; in_rs2 = 7; in_rd = 6; in_wr_rd = 1;
    br_valid = 1; br_mispredict = 1; br_tag = 0;
    #1;
    check("mp_ready", in_ready, 0);
    cyc(1);
    br_valid = 0; br_mispredict = 0;
    check("mp_outv", out_valid, 0);
    check("mp_flcnt", dut.fl_count_q, 96);
    check("mp_ckcnt", dut.ck_count_q, 0);
    out_ready = 1;
    cyc(1);
    in_valid = 0; in_wr_rd = 0;
    check("mp_acc", out_valid, 1);
    check("mp_pdnew", out_pd_new, 33);
    check("mp_ps1", out_ps1, 1);
    check("mp_ps2", out_ps2, 32);
    check("mp_pdold", out_pd_old, 6);
    check("mp_rob", out_rob_tag, 2);

    // checkpoint capacity and out-of-order resolves
    for (int k = 0; k < 4; k++) rn(0, 0, 0, 0, 1);
    check("ck4_tag", out_br_tag, 3);
    check("ck4_cnt", dut.ck_count_q, 4);
    in_valid = 1; in_is_br = 1;
    #1;
    check("ck5_stall", in_ready, 0);
    in_valid = 0; in_is_br = 0;
    resolve(2, 0);
    cyc(1);
    check("res2_cnt", dut.ck_count_q, 4);
    resolve(0, 0);
    cyc(1);
    check("res0_cnt", dut.ck_count_q, 3);
    resolve(1, 0);
    cyc(3);
    check("res1_cnt", dut.ck_count_q, 1);
    rn(0, 0, 0, 0, 1);
    check("ck5_acc", out_valid, 1);
    check("ck5_tag", out_br_tag, 0);
    check("ck5_cnt", dut.ck_count_q, 2);

    // async reset between edges
    out_ready = 0;
    #3;
    reset_n = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_isbr", out_is_br, 0);
    #10;
    reset_n = 1;
    out_ready = 1;
    @(posedge clk);
    #1;
    rn(0, 0, 9, 1, 0);
    check("arst_pdnew", out_pd_new, 32);
    check("arst_rob", out_rob_tag, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
